// File: rtl/disp_pkg.sv
// disp_pkg: shared constants, hex segment table and brightness mapping for the display scanner
//   DIGITS   : number of multiplexed digits
//   SEG_OFF  : active-low segment pattern with every segment dark
//   AN_OFF   : active-low anode pattern with every digit disabled
//   hex2seg  : 4-bit value to active-low a..g pattern (a on bit 0)
//   on_slots : brightness level to number of lit PWM slots out of 16
package disp_pkg;
   localparam int DIGITS = 4;
   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [3:0] AN_OFF = 4'hF;
   localparam logic [6:0] SEG_TAB [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
   function automatic logic [6:0] hex2seg(input logic [3:0] h);
      return SEG_TAB[h];
   endfunction
   // 4/8/12/16 lit slots; level 3 keeps the digit on for the whole period
   function automatic logic [4:0] on_slots(input logic [1:0] b);
      return {1'b0, b, 2'b00} + 5'd4;
   endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to active-low 7-segment lookup
//   hex : nibble to display
//   seg : segments a..g on [0]..[6], active-low
module seg7_decode
   import disp_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);
   assign seg = hex2seg(hex);
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 4-digit common-anode 7-segment scanner with PWM brightness and tear-free word updates
//   clk, rst_n       : clock, synchronous active-low reset
//   wr_valid/wr_data : producer word (digit0 in [3:0] .. digit3 in [15:12])
//   wr_ready         : pending buffer empty
//   bright           : brightness level 0..3, latched at each digit period start
//   blink_mask       : per-digit blink enable (only with DISP_SCAN_BLINK_EN defined)
//   seg, an          : registered active-low segment and anode drives
//   frame_done       : one-cycle pulse after each frame wrap
// Optional feature macro: DISP_SCAN_BLINK_EN (adds blink_mask and BLINK_FRAMES).
module disp_scan_ctrl
   import disp_pkg::*;
#(
   parameter int CLK_DIV = 625,
   parameter int PWM_STEPS = 16
`ifdef DISP_SCAN_BLINK_EN
   ,
   parameter int BLINK_FRAMES = 32
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_valid,
   input  logic [15:0] wr_data,
   output logic        wr_ready,
   input  logic [1:0]  bright,
`ifdef DISP_SCAN_BLINK_EN
   input  logic [3:0]  blink_mask,
`endif
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        frame_done
);
   localparam int PW = $clog2(CLK_DIV);
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0] slot_q, slot_d;
   logic [1:0] digit_q, digit_d, bright_q, bright_d;
   logic [15:0] disp_q, disp_d, pend_q, pend_d;
   logic pend_full_q, pend_full_d, wr_ready_q, wr_ready_d, frame_done_q, frame_done_d;
   logic run_q, run_d;
   logic [6:0] seg_q, seg_d, dec_seg;
   logic [3:0] an_q, an_d, nib;
   logic tick, slot_wrap, frame_wrap, accept, blank, lit;
`ifdef DISP_SCAN_BLINK_EN
   localparam int FW = $clog2(BLINK_FRAMES + 1);
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic phase_q, phase_d, phase_end;
`endif

   seg7_decode u_dec (.hex(nib), .seg(dec_seg));

   always_comb begin
      tick = presc_q == PW'(CLK_DIV - 1);
      slot_wrap = tick && slot_q == 4'(PWM_STEPS - 1);
      frame_wrap = slot_wrap && digit_q == 2'(DIGITS - 1);
      accept = wr_valid && wr_ready_q;
      presc_d = tick ? '0 : presc_q + PW'(1);
      slot_d = tick ? slot_q + 4'd1 : slot_q;
      digit_d = slot_wrap ? digit_q + 2'd1 : digit_q;
      bright_d = slot_wrap ? bright : bright_q;
      // a pending word only replaces the shown word at the frame wrap, so a frame is never mixed
      disp_d = (frame_wrap && pend_full_q) ? pend_q : disp_q;
      pend_d = accept ? wr_data : pend_q;
      pend_full_d = accept || (pend_full_q && !frame_wrap);
      // ready trails the pending flag by a cycle so it rises the cycle after frame_done
      wr_ready_d = !(pend_full_q || accept);
      frame_done_d = frame_wrap;
      // holds outputs dark on the first edge after reset release
      run_d = 1'b1;
      blank = 1'b0;
`ifdef DISP_SCAN_BLINK_EN
      phase_end = fcnt_q == FW'(BLINK_FRAMES - 1);
      fcnt_d = frame_wrap ? (phase_end ? '0 : fcnt_q + FW'(1)) : fcnt_q;
      phase_d = (frame_wrap && phase_end) ? !phase_q : phase_q;
      blank = phase_q && blink_mask[digit_q];
`endif
      nib = disp_q[4*digit_q +: 4];
      lit = run_q && !blank && ({1'b0, slot_q} < on_slots(bright_q));
      an_d = lit ? ~(4'b0001 << digit_q) : AN_OFF;
      seg_d = lit ? dec_seg : SEG_OFF;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q <= '0;
         slot_q <= '0;
         digit_q <= '0;
         bright_q <= '0;
         disp_q <= '0;
         pend_q <= '0;
         pend_full_q <= 1'b0;
         wr_ready_q <= 1'b1;
         frame_done_q <= 1'b0;
         run_q <= 1'b0;
         seg_q <= SEG_OFF;
         an_q <= AN_OFF;
      end else begin
         presc_q <= presc_d;
         slot_q <= slot_d;
         digit_q <= digit_d;
         bright_q <= bright_d;
         disp_q <= disp_d;
         pend_q <= pend_d;
         pend_full_q <= pend_full_d;
         wr_ready_q <= wr_ready_d;
         frame_done_q <= frame_done_d;
         run_q <= run_d;
         seg_q <= seg_d;
         an_q <= an_d;
      end
   end

`ifdef DISP_SCAN_BLINK_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fcnt_q <= '0;
         phase_q <= 1'b0;
      end else begin
         fcnt_q <= fcnt_d;
         phase_q <= phase_d;
      end
   end
`endif

   assign seg = seg_q;
   assign an = an_q;
   assign wr_ready = wr_ready_q;
   assign frame_done = frame_done_q;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: self-checking bench for disp_scan_ctrl against a cycle-position reference model
module tb_disp_scan_ctrl;
   localparam int D = 4, P = 16 * D, F = 4 * P, BF = 2;
   logic clk = 1'b0, rst_n = 1'b0, wr_valid = 1'b0;
   logic [15:0] wr_data = '0;
   logic [1:0] bright = '0;
   logic [6:0] seg;
   logic [3:0] an;
   logic wr_ready, frame_done;
`ifdef DISP_SCAN_BLINK_EN
   logic [3:0] blink_mask = '0;
`endif
   int errors = 0, checks = 0;
   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   always #5 clk = ~clk;

   disp_scan_ctrl #(
      .CLK_DIV(D),
      .PWM_STEPS(16)
`ifdef DISP_SCAN_BLINK_EN
      , .BLINK_FRAMES(BF)
`endif
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .wr_valid(wr_valid),
      .wr_data(wr_data),
      .wr_ready(wr_ready),
      .bright(bright),
`ifdef DISP_SCAN_BLINK_EN
      .blink_mask(blink_mask),
`endif
      .seg(seg),
      .an(an),
      .frame_done(frame_done)
   );

   // reference model: position inside the frame is derived arithmetically from cycles since release
   int m_c, pos, dig, slot;
   logic [1:0] m_br;
   logic [15:0] m_disp, m_pend;
   logic m_full, m_rdy, exp_fd, lit;
   logic [3:0] exp_an;
   logic [6:0] exp_seg;

   always_comb begin
      pos = m_c % F;
      dig = pos / P;
      slot = (pos / D) % 16;
      lit = (m_c != 0) && (slot < 4 * m_br + 4);
`ifdef DISP_SCAN_BLINK_EN
      if (((m_c / F) / BF) % 2 == 1 && blink_mask[dig]) lit = 1'b0;
`endif
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         m_c <= 0;
         m_br <= '0;
         m_disp <= '0;
         m_pend <= '0;
         m_full <= 1'b0;
         m_rdy <= 1'b1;
         exp_an <= 4'hF;
         exp_seg <= 7'h7F;
         exp_fd <= 1'b0;
      end else begin
         exp_an <= lit ? ~(4'b0001 << dig) : 4'hF;
         exp_seg <= lit ? seg_tab[m_disp[4*dig +: 4]] : 7'h7F;
         exp_fd <= pos == F - 1;
         if (m_c % P == P - 1) m_br <= bright;
         if (pos == F - 1 && m_full) begin
            m_disp <= m_pend;
            m_full <= 1'b0;
         end
         if (wr_valid && m_rdy) begin
            m_pend <= wr_data;
            m_full <= 1'b1;
         end
         m_rdy <= !(m_full || (wr_valid && m_rdy));
         m_c <= m_c + 1;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic test_reset;
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({an, seg, wr_ready, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d: an=%h seg=%h rdy=%b fd=%b, required an=f seg=7f rdy=1 fd=0", i, an, seg, wr_ready, frame_done);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({an, seg, wr_ready, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_release: an=%h seg=%h rdy=%b fd=%b, required an=f seg=7f rdy=1 fd=0", an, seg, wr_ready, frame_done);
      end
   endtask

   task automatic test_write_display;
      int fd_at = -1, n0 = 0, n3 = 0, bad0 = 0, bad19 = 0, bad79 = 0;
      bright = 2'd3;
      for (int i = 0; i < 2 * F + 8; i++) begin
         @(negedge clk);
         checks++;
         if ({an, seg, wr_ready, frame_done} !== {exp_an, exp_seg, m_rdy, exp_fd}) begin
            errors++;
            $display("FAIL write_scan t=%0t: an=%b seg=%h rdy=%b fd=%b, required an=%b seg=%h rdy=%b fd=%b", $time, an, seg, wr_ready, frame_done, exp_an, exp_seg, m_rdy, exp_fd);
         end
         if (i == 2) begin
            wr_valid = 1'b1;
            wr_data = 16'h1234;
         end
         if (i == 3) begin
            wr_valid = 1'b0;
            checks++;
            if (wr_ready !== 1'b0) begin
               errors++;
               $display("FAIL write_ready_drop: wr_ready=%b, required 0", wr_ready);
            end
         end
         if (fd_at < 0 && frame_done) fd_at = i;
         else if (fd_at >= 0 && i - fd_at <= F) begin
            if (an == 4'b1110) begin
               n0++;
               if (seg !== 7'h19) bad19++;
            end
            if (an == 4'b0111) begin
               n3++;
               if (seg !== 7'h79) bad79++;
            end
         end
         if (fd_at < 0 && an != 4'hF && seg !== 7'h40) bad0++;
      end
      checks++;
      if (fd_at < 0) begin
         errors++;
         $display("FAIL write_frame_done: no frame_done seen within %0d cycles", 2 * F + 8);
      end
      checks++;
      if (n0 != 64 || n3 != 64) begin
         errors++;
         $display("FAIL write_on_time: digit0=%0d digit3=%0d lit cycles, required 64 and 64", n0, n3);
      end
      checks++;
      if (bad19 != 0 || bad79 != 0) begin
         errors++;
         $display("FAIL write_seg: %0d digit0 and %0d digit3 wrong patterns, required 0 (19 and 79)", bad19, bad79);
      end
      checks++;
      if (bad0 != 0) begin
         errors++;
         $display("FAIL write_old_word: %0d non-zero patterns before commit, required 0", bad0);
      end
   endtask

   task automatic test_brightness;
      int st = 0, j = 0;
      int cnt [4] = '{0, 0, 0, 0};
      int req [4] = '{16, 16, 48, 48};
      for (int i = 0; i < 3 * F && st < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({an, seg, wr_ready, frame_done} !== {exp_an, exp_seg, m_rdy, exp_fd}) begin
            errors++;
            $display("FAIL bright_scan t=%0t: an=%b seg=%h rdy=%b fd=%b, required an=%b seg=%h rdy=%b fd=%b", $time, an, seg, wr_ready, frame_done, exp_an, exp_seg, m_rdy, exp_fd);
         end
         if (st == 0 && wr_ready) begin
            wr_valid = 1'b1;
            wr_data = 16'h8888;
            bright = 2'd0;
            st = 1;
         end else if (st == 1) begin
            wr_valid = 1'b0;
            if (frame_done) st = 2;
         end else if (st == 2) begin
            j++;
            if (an != 4'hF) cnt[(j - 1) / P]++;
            if (j == P + 20) bright = 2'd2;
            if (j == F) st = 3;
         end
      end
      checks++;
      if (st != 3) begin
         errors++;
         $display("FAIL bright_timeout: reached step %0d, required 3", st);
      end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (cnt[k] != req[k]) begin
            errors++;
            $display("FAIL bright_digit%0d: lit %0d cycles, required %0d", k, cnt[k], req[k]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [15:0] words [2] = '{16'hAAAA, 16'h5555};
      logic [6:0] d0 [2] = '{7'h7F, 7'h7F};
      logic got [2] = '{1'b0, 1'b0};
      int idx = 0, nfd = 0, fd1 = -1, rise = -1, acc_i = -1;
      logic will = 1'b0, prev_rdy = 1'b1;
      bright = 2'd3;
      for (int i = 0; i < 4 * F && nfd < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({an, seg, wr_ready, frame_done} !== {exp_an, exp_seg, m_rdy, exp_fd}) begin
            errors++;
            $display("FAIL b2b_scan t=%0t: an=%b seg=%h rdy=%b fd=%b, required an=%b seg=%h rdy=%b fd=%b", $time, an, seg, wr_ready, frame_done, exp_an, exp_seg, m_rdy, exp_fd);
         end
         if (will) begin
            idx++;
            if (idx == 1) acc_i = i;
         end
         if (idx >= 1 && i > acc_i && frame_done) begin
            nfd++;
            if (nfd == 1) fd1 = i;
         end
         if (nfd == 1 && rise < 0 && wr_ready && !prev_rdy) rise = i;
         if (nfd >= 1 && nfd <= 2 && an == 4'b1110 && !got[nfd - 1]) begin
            got[nfd - 1] = 1'b1;
            d0[nfd - 1] = seg;
         end
         wr_valid = idx < 2;
         if (idx < 2) wr_data = words[idx];
         will = wr_valid && wr_ready;
         prev_rdy = wr_ready;
      end
      wr_valid = 1'b0;
      checks++;
      if (idx != 2 || nfd < 3) begin
         errors++;
         $display("FAIL b2b_progress: accepted %0d words, %0d frames, required 2 words and 3 frames", idx, nfd);
      end
      checks++;
      if (fd1 < 0 || rise != fd1 + 1) begin
         errors++;
         $display("FAIL b2b_ready_rise: rose at %0d, frame_done at %0d, required one cycle later", rise, fd1);
      end
      checks++;
      if (d0[0] !== 7'h08 || d0[1] !== 7'h12) begin
         errors++;
         $display("FAIL b2b_words: digit0 %h then %h, required 08 then 12", d0[0], d0[1]);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 3 * F; i++) begin
         @(negedge clk);
         checks++;
         if ({an, seg, wr_ready, frame_done} !== {exp_an, exp_seg, m_rdy, exp_fd}) begin
            errors++;
            $display("FAIL rand_scan t=%0t: an=%b seg=%h rdy=%b fd=%b, required an=%b seg=%h rdy=%b fd=%b", $time, an, seg, wr_ready, frame_done, exp_an, exp_seg, m_rdy, exp_fd);
         end
         if ($urandom_range(0, 63) == 0) bright = 2'($urandom_range(0, 3));
         wr_valid = $urandom_range(0, 7) == 0;
         wr_data = 16'($urandom);
      end
      wr_valid = 1'b0;
   endtask

   task automatic test_reset_midframe;
      int st = 0, k = 0, j = 0, stale = 0;
      bright = 2'd3;
      for (int i = 0; i < 4 * F + 100 && st < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({an, seg, wr_ready, frame_done} !== {exp_an, exp_seg, m_rdy, exp_fd}) begin
            errors++;
            $display("FAIL rstmid_scan t=%0t: an=%b seg=%h rdy=%b fd=%b, required an=%b seg=%h rdy=%b fd=%b", $time, an, seg, wr_ready, frame_done, exp_an, exp_seg, m_rdy, exp_fd);
         end
         if (st == 0) begin
            if (frame_done) st = 1;
         end else if (st == 1) begin
            if (wr_ready) begin
               wr_valid = 1'b1;
               wr_data = 16'hBEEF;
               st = 2;
            end
         end else if (st == 2) begin
            wr_valid = 1'b0;
            k++;
            if (k == 40) begin
               checks++;
               if (wr_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL rstmid_pending: wr_ready=%b before reset, required 0", wr_ready);
               end
               rst_n = 1'b0;
               st = 3;
            end
         end else if (st == 3) begin
            checks++;
            if ({an, seg, wr_ready, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
               errors++;
               $display("FAIL rstmid_reset: an=%h seg=%h rdy=%b fd=%b, required an=f seg=7f rdy=1 fd=0", an, seg, wr_ready, frame_done);
            end
            rst_n = 1'b1;
            st = 4;
         end else begin
            j++;
            if (an != 4'hF && seg !== 7'h40) stale++;
            if (j == 2 * F) st = 5;
         end
      end
      checks++;
      if (st != 5 || stale != 0) begin
         errors++;
         $display("FAIL rstmid_stale: step %0d, %0d stale patterns, required step 5 and 0", st, stale);
      end
   endtask

`ifdef DISP_SCAN_BLINK_EN
   task automatic test_blink;
      int c0 [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
      int c1_f2 = 0;
      int req [8] = '{0, 64, 0, 0, 64, 64, 0, 0};
      rst_n = 1'b0;
      bright = 2'd3;
      blink_mask = 4'b0001;
      @(negedge clk);
      rst_n = 1'b1;
      for (int j = 1; j <= 8 * F; j++) begin
         @(negedge clk);
         checks++;
         if ({an, seg, wr_ready, frame_done} !== {exp_an, exp_seg, m_rdy, exp_fd}) begin
            errors++;
            $display("FAIL blink_scan t=%0t: an=%b seg=%h rdy=%b fd=%b, required an=%b seg=%h rdy=%b fd=%b", $time, an, seg, wr_ready, frame_done, exp_an, exp_seg, m_rdy, exp_fd);
         end
         if (an == 4'b1110) c0[(j - 1) / F]++;
         if (an == 4'b1101 && (j - 1) / F == 2) c1_f2++;
      end
      for (int f = 1; f < 8; f++) begin
         checks++;
         if (c0[f] != req[f]) begin
            errors++;
            $display("FAIL blink_frame%0d: digit0 lit %0d cycles, required %0d", f, c0[f], req[f]);
         end
      end
      checks++;
      if (c1_f2 != 64) begin
         errors++;
         $display("FAIL blink_digit1: lit %0d cycles in frame 2, required 64", c1_f2);
      end
      blink_mask = 4'b0000;
   endtask
`endif

   initial begin
      test_reset();
      test_write_display();
      test_brightness();
      test_back_to_back();
      test_random();
      test_reset_midframe();
`ifdef DISP_SCAN_BLINK_EN
      test_blink();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
